ifport_arbiter: RTL and testbench
=================================

# ifport_arbiter

Round-robin arbiter that lets several interface-logic store ports share a single external-memory (ERAM) port. It sits between the per-tile interface-logic store paths and the ERAM front end. It grants exactly one requester at a time, drives that requester's store-enable, and forwards its forward tokens to ERAM. It also returns ERAM's backward tokens to the winner, nacks the losers, and recovers from stalled owners with an idle watchdog.

## Interface
Parameters:
- NUM_REQ, 4, number of requesting store ports (2..8)
- WIDTH_ID, $clog2(NUM_REQ), width of the grant index
- IDLE_LIMIT, 64, consecutive idle cycles in transfer before forced release
- WIDTH_TO, $clog2(IDLE_LIMIT+1), watchdog counter width

Ports:
- clock  in  1  clock
- reset  in  1  synchronous, active-high reset
- I_Req  in  NUM_REQ  per-port header/request flag (level, held until granted)
- I_FTk  in  FTk_t[NUM_REQ]  per-port forward token from store path
- O_BTk  out  BTk_t[NUM_REQ]  per-port backward token to store path
- O_St  out  NUM_REQ  one-hot store-enable/grant to store path
- O_FTk_IF  out  FTk_t  forward token to ERAM
- I_BTk_IF  in  BTk_t  backward token from ERAM
- O_Grant_ID  out  WIDTH_ID  index of current owner (valid while O_Busy)
- O_Busy  out  1  port owned
- O_Abort  out  1  one-cycle pulse on watchdog release

## Operation
- FSM states:
  - ARB_IDLE: if any I_Req, select winner round-robin starting at ptr; register owner, go ARB_XFER.
  - ARB_XFER: forward owner's I_FTk to O_FTk_IF, route I_BTk_IF to O_BTk[owner].
    - On term (owner I_FTk.v & .a & .r, forwarded) go ARB_RELEASE.
    - On watchdog expiry go ARB_RELEASE with O_Abort.
  - ARB_RELEASE: one cycle; O_St cleared, O_FTk_IF = '0; ptr <= owner+1 (mod NUM_REQ); go ARB_IDLE.
- Round-robin: priority order ptr, ptr+1, …, wrap at NUM_REQ-1→0. ptr resets to 0.
- Losers with I_Req high get O_BTk.n=1 (hold). All other O_BTk fields are 0.
- Owner's O_BTk = I_BTk_IF unmodified. ERAM nack stalls the owner, not the arbiter.
- Watchdog:
  - Counter clears on any owner I_FTk.v or on entering ARB_XFER; increments otherwise in ARB_XFER.
  - When it reaches IDLE_LIMIT: O_Abort=1 for one cycle, and the terminal token is not synthesised.
- Owner dropping I_Req in ARB_XFER has no effect; only term or watchdog releases.
- Non-owner I_FTk are never forwarded; O_FTk_IF = '0 outside ARB_XFER.

## Timing
- Reset values: O_St=0, O_FTk_IF='0, O_BTk all '0, O_Grant_ID=0, O_Busy=0, O_Abort=0, state ARB_IDLE, ptr=0, counter=0.
- Request latency: I_Req high at cycle t in ARB_IDLE → O_St[k]=1, O_Busy=1 at t+1.
- Data path is combinational in ARB_XFER (0-cycle). Owner's store path registers the data itself.
- Term token at cycle t → O_St=0 at t+1 (ARB_RELEASE) → next grant earliest at t+3. Exactly two bubble cycles.
- Simultaneous requests: one grant only, per ptr order. A request arriving during ARB_RELEASE is evaluated at ARB_IDLE.
- Term and watchdog expiry in the same cycle: term wins, no O_Abort.
- Reset mid-transfer: immediate return to reset values next edge; no term emitted to ERAM.

## Structure
- pkg_en (existing): FTk_t, BTk_t.
- New shared package entry: typedef enum fsm_ifport_arb {ARB_IDLE, ARB_XFER, ARB_RELEASE}.
- Sub-module RRPick: combinational round-robin priority encoder (inputs req vector, ptr; outputs valid, index). Reusable by other arbiters.

## Test plan
- Single request: I_Req=4'b0100 at t → O_St=4'b0100, O_Grant_ID=2 at t+1; 5 data tokens forwarded unchanged; term at t+7 → O_St=0 at t+8, O_Busy=0 at t+9.
- Fairness: I_Req=4'b1111 held, each port sends 3 tokens + term → grant order 0,1,2,3,0. Losers see O_BTk.n=1 throughout.
- ERAM backpressure: I_BTk_IF.n=1 for 4 cycles mid-transfer → owner O_BTk.n=1 for the same cycles; O_St held; no watchdog increment while owner valid.
- Watchdog: owner goes silent after 2 tokens → O_Abort pulse after exactly 64 idle cycles; then grant passes to the next requester.
- Term and expiry coincide at count 63→64 with term → no O_Abort, normal release.
- Reset asserted in ARB_XFER → next cycle all outputs at reset values; ptr=0, so port 0 wins the next contention.

Source files
------------

// File: rtl/ifport_arbiter_pkg.sv
// Shared types for the interface-logic store-port arbiter: forward/backward tokens and FSM states.
package ifport_arbiter_pkg;

    localparam int FTK_DW = 16;
    localparam int BTK_DW = 8;

    // v/a/r all set together marks the terminal token of a transfer
    typedef struct packed {
        logic              v;
        logic              a;
        logic              r;
        logic [FTK_DW-1:0] d;
    } FTk_t;

    typedef struct packed {
        logic              n;
        logic [BTK_DW-1:0] d;
    } BTk_t;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_XFER    = 2'd1,
        ARB_RELEASE = 2'd2
    } fsm_ifport_arb;

    function automatic logic is_term(input FTk_t t);
        return t.v & t.a & t.r;
    endfunction

endpackage

// File: rtl/ifport_arbiter_if.sv
// Store-port side and ERAM side of the arbiter; master is the arbiter's view.
interface ifport_arbiter_if
    import ifport_arbiter_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int WIDTH_ID = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]  I_Req;
    FTk_t [NUM_REQ-1:0]  I_FTk;
    BTk_t [NUM_REQ-1:0]  O_BTk;
    logic [NUM_REQ-1:0]  O_St;
    FTk_t                O_FTk_IF;
    BTk_t                I_BTk_IF;
    logic [WIDTH_ID-1:0] O_Grant_ID;
    logic                O_Busy;
    logic                O_Abort;

    modport master (
        input  I_Req, I_FTk, I_BTk_IF,
        output O_BTk, O_St, O_FTk_IF, O_Grant_ID, O_Busy, O_Abort
    );

    modport slave (
        output I_Req, I_FTk, I_BTk_IF,
        input  O_BTk, O_St, O_FTk_IF, O_Grant_ID, O_Busy, O_Abort
    );

endinterface

// File: rtl/ifport_arbiter_rrpick.sv
// Round-robin priority pick: first set request at or after ptr, wrapping at N-1.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the pick is consumed.
module ifport_arbiter_rrpick #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         valid,
    output logic [W-1:0] idx
);
    int j;

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        j     = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!valid && req[j]) begin
                valid = 1'b1;
                idx   = W'(j);
            end
        end
    end

endmodule

// File: rtl/ifport_arbiter.sv
// Round-robin arbiter giving one interface-logic store port at a time the ERAM port.
// Latency: grant one cycle after request; token paths combinational while owned; two bubble cycles between owners.
// Backpressure: ERAM nack passes straight to the owner; waiting requesters are held with n=1; idle watchdog frees stalled owners.
module ifport_arbiter
    import ifport_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int WIDTH_ID   = $clog2(NUM_REQ),
    parameter int IDLE_LIMIT = 64,
    parameter int WIDTH_TO   = $clog2(IDLE_LIMIT + 1)
) (
    input logic              clock,
    input logic              reset,
    ifport_arbiter_if.master arb
);
    fsm_ifport_arb       state_q, state_d;
    logic [WIDTH_ID-1:0] owner_q, owner_d;
    logic [WIDTH_ID-1:0] ptr_q, ptr_d;
    logic [WIDTH_TO-1:0] wdog_q, wdog_d;

    logic                pick_vld;
    logic [WIDTH_ID-1:0] pick_idx;
    FTk_t                own_ftk;
    logic                own_term;
    logic                wdog_exp;

    logic [NUM_REQ-1:0]  st;
    FTk_t                ftk_if;
    BTk_t [NUM_REQ-1:0]  btk;
    logic                abort;

    ifport_arbiter_rrpick #(.N(NUM_REQ), .W(WIDTH_ID)) u_pick (
        .req   (arb.I_Req),
        .ptr   (ptr_q),
        .valid (pick_vld),
        .idx   (pick_idx)
    );

    assign own_ftk  = arb.I_FTk[owner_q];
    assign own_term = is_term(own_ftk);
    assign wdog_exp = (wdog_q == WIDTH_TO'(IDLE_LIMIT));

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        wdog_d  = '0;
        st      = '0;
        ftk_if  = '0;
        abort   = 1'b0;
        unique case (state_q)
            ARB_IDLE: begin
                if (pick_vld) begin
                    owner_d = pick_idx;
                    state_d = ARB_XFER;
                end
            end
            ARB_XFER: begin
                st[owner_q] = 1'b1;
                ftk_if      = own_ftk;
                // a terminal token always beats a simultaneous watchdog expiry
                if (own_term) begin
                    state_d = ARB_RELEASE;
                end else if (wdog_exp) begin
                    abort   = 1'b1;
                    state_d = ARB_RELEASE;
                end else if (!own_ftk.v) begin
                    wdog_d = wdog_q + WIDTH_TO'(1);
                end
            end
            ARB_RELEASE: begin
                ptr_d   = (owner_q == WIDTH_ID'(NUM_REQ - 1)) ? '0 : owner_q + WIDTH_ID'(1);
                state_d = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            btk[i] = '0;
            if (state_q == ARB_XFER && owner_q == WIDTH_ID'(i)) begin
                btk[i] = arb.I_BTk_IF;
            end else begin
                btk[i].n = arb.I_Req[i];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ARB_IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            wdog_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            wdog_q  <= wdog_d;
        end
    end

    assign arb.O_St       = st;
    assign arb.O_FTk_IF   = ftk_if;
    assign arb.O_BTk      = btk;
    assign arb.O_Grant_ID = owner_q;
    assign arb.O_Busy     = (state_q != ARB_IDLE);
    assign arb.O_Abort    = abort;

endmodule

// File: tb/tb_ifport_arbiter.sv
// Bench for ifport_arbiter: cycle-level ownership model checked every cycle, plus directed literal checks.
module tb_ifport_arbiter;
    import ifport_arbiter_pkg::*;

    localparam int N   = 4;
    localparam int LIM = 64;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    ifport_arbiter_if #(.NUM_REQ(N)) bus ();

    ifport_arbiter #(.NUM_REQ(N), .IDLE_LIMIT(LIM)) dut (
        .clock (clock),
        .reset (reset),
        .arb   (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;
    bit started = 1'b0;

    // model: who owns the port, whether this is the release cycle, rotation start, idle run length
    int   m_owner  = -1;
    bit   m_rel    = 1'b0;
    int   m_ptr    = 0;
    int   m_idle   = 0;
    int   m_aborts = 0;
    int   m_log[$];

    int   fair_exp[5] = '{0, 1, 2, 3, 0};
    int   log_exp[12] = '{0, 1, 2, 3, 0, 2, 0, 1, 3, 1, 2, 0};

    bit             c_xfer, c_term, c_eab;
    FTk_t           c_of;
    logic [N-1:0]   c_st;
    BTk_t           c_eb;
    int             c_pick;

    function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, got, exp, $time);
    endfunction

    function automatic FTk_t mk(input logic v, input logic a, input logic r, input logic [15:0] d);
        FTk_t t;
        t.v = v; t.a = a; t.r = r; t.d = d;
        return t;
    endfunction

    always @(negedge clock) begin
        if (started) begin
            c_xfer = (m_owner >= 0) && !m_rel;
            c_of   = '0;
            c_st   = '0;
            if (c_xfer) begin
                c_of          = bus.I_FTk[m_owner];
                c_st[m_owner] = 1'b1;
            end
            c_term = c_xfer && c_of.v && c_of.a && c_of.r;
            c_eab  = c_xfer && !c_term && (m_idle >= LIM);
            chk("m_st",     32'(bus.O_St),     32'(c_st));
            chk("m_ftk_if", 32'(bus.O_FTk_IF), 32'(c_of));
            chk("m_busy",   32'(bus.O_Busy),   32'(m_owner >= 0));
            chk("m_abort",  32'(bus.O_Abort),  32'(c_eab));
            if (m_owner >= 0) chk("m_grant_id", 32'(bus.O_Grant_ID), 32'(m_owner));
            for (int i = 0; i < N; i++) begin
                c_eb = '0;
                if (c_xfer && i == m_owner) c_eb = bus.I_BTk_IF;
                else c_eb.n = bus.I_Req[i];
                chk("m_btk", 32'(bus.O_BTk[i]), 32'(c_eb));
            end
            if (reset) begin
                m_owner = -1; m_rel = 1'b0; m_ptr = 0; m_idle = 0;
            end else if (m_owner < 0) begin
                c_pick = -1;
                for (int k = 0; k < N; k++)
                    if (c_pick < 0 && bus.I_Req[(m_ptr + k) % N]) c_pick = (m_ptr + k) % N;
                if (c_pick >= 0) begin
                    m_owner = c_pick;
                    m_idle  = 0;
                    m_log.push_back(c_pick);
                end
            end else if (m_rel) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
                m_rel   = 1'b0;
            end else begin
                if (c_term || c_eab) m_rel = 1'b1;
                if (c_eab) m_aborts++;
                m_idle = c_of.v ? 0 : m_idle + 1;
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_grant(output int id, output int waited);
        bit got;
        got = 1'b0; id = -1; waited = 0;
        for (int c = 0; c < 20 && !got; c++) begin
            if (bus.O_St != '0) begin
                got = 1'b1;
                id  = int'(bus.O_Grant_ID);
            end else begin
                step();
                waited++;
            end
        end
        chk("grant_seen", 32'(got), 32'(1));
    endtask

    task automatic xfer(input int id, input int ntok);
        for (int k = 0; k < ntok; k++) begin
            bus.I_FTk[id] = mk(1'b1, 1'b0, 1'b0, 16'(16'h100 * id + k));
            step();
        end
        bus.I_FTk[id] = mk(1'b1, 1'b1, 1'b1, 16'hFFFF);
        step();
        bus.I_FTk[id] = '0;
    endtask

    initial begin
        int id, waited, silent;
        int gl[$];
        bus.I_Req = '0; bus.I_FTk = '0; bus.I_BTk_IF = '0;
        reset = 1'b1;
        @(posedge clock); #1;
        started = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clock);
        chk("rst_st",    32'(bus.O_St),       0);
        chk("rst_busy",  32'(bus.O_Busy),     0);
        chk("rst_gid",   32'(bus.O_Grant_ID), 0);
        chk("rst_abort", 32'(bus.O_Abort),    0);
        chk("rst_ftk",   32'(bus.O_FTk_IF),   0);
        chk("rst_btk0",  32'(bus.O_BTk[0]),   0);

        // fairness: all four requesting, each owner sends 3 tokens + term
        bus.I_Req = 4'hF;
        for (int g = 0; g < 5; g++) begin
            wait_grant(id, waited);
            gl.push_back(id);
            if (g == 1) chk("bubble_cycles", waited, 2);
            if (g == 4) bus.I_Req = '0;
            if (g == 0) begin
                @(negedge clock);
                chk("loser_hold", 32'(bus.O_BTk[3].n), 1);
                chk("owner_no_hold", 32'(bus.O_BTk[0].n), 0);
                step();
            end
            xfer(id, 3);
        end
        for (int g = 0; g < 5; g++) chk("fair_order", gl[g], fair_exp[g]);

        // single request on port 2: 5 tokens then term
        repeat (3) step();
        bus.I_Req = 4'b0100;
        @(negedge clock);
        chk("sr_pre_st", 32'(bus.O_St), 0);
        step();
        bus.I_Req = '0;
        @(negedge clock);
        chk("sr_st",   32'(bus.O_St), 32'h4);
        chk("sr_gid",  32'(bus.O_Grant_ID), 2);
        chk("sr_busy", 32'(bus.O_Busy), 1);
        for (int k = 0; k < 5; k++) begin
            step();
            bus.I_FTk[2] = mk(1'b1, 1'b0, 1'b0, 16'(16'hA0 + k));
            @(negedge clock);
            chk("sr_tok", 32'(bus.O_FTk_IF), 32'({3'b100, 16'(16'hA0 + k)}));
        end
        step();
        bus.I_FTk[2] = mk(1'b1, 1'b1, 1'b1, 16'h00FF);
        @(negedge clock);
        chk("sr_term", 32'(bus.O_FTk_IF), 32'({3'b111, 16'h00FF}));
        step();
        bus.I_FTk[2] = '0;
        @(negedge clock);
        chk("sr_rel_st",   32'(bus.O_St), 0);
        chk("sr_rel_busy", 32'(bus.O_Busy), 1);
        step();
        @(negedge clock);
        chk("sr_idle_busy", 32'(bus.O_Busy), 0);

        // ERAM backpressure on owner 0 for 4 cycles
        step();
        bus.I_Req = 4'b0001;
        wait_grant(id, waited);
        chk("bp_id", id, 0);
        bus.I_Req = '0;
        bus.I_FTk[0] = mk(1'b1, 1'b0, 1'b0, 16'h0055);
        step();
        bus.I_BTk_IF.n = 1'b1;
        bus.I_BTk_IF.d = 8'h5A;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            chk("bp_owner_n", 32'(bus.O_BTk[0].n), 1);
            chk("bp_owner_d", 32'(bus.O_BTk[0].d), 32'h5A);
            chk("bp_st",      32'(bus.O_St), 1);
            step();
        end
        bus.I_BTk_IF = '0;
        @(negedge clock);
        chk("bp_release_n", 32'(bus.O_BTk[0].n), 0);
        step();
        xfer(0, 0);

        // watchdog: port 1 sends 2 tokens then goes silent; port 3 waits
        repeat (2) step();
        bus.I_Req = 4'b0010;
        wait_grant(id, waited);
        chk("wd_id", id, 1);
        bus.I_Req = 4'b1000;
        bus.I_FTk[1] = mk(1'b1, 1'b0, 1'b0, 16'h0001);
        step();
        bus.I_FTk[1] = mk(1'b1, 1'b0, 1'b0, 16'h0002);
        step();
        bus.I_FTk[1] = '0;
        silent = 0;
        while (silent < 100) begin
            @(negedge clock);
            if (bus.O_Abort) break;
            silent++;
            step();
        end
        chk("wd_idle_cycles", silent, 64);
        step();
        @(negedge clock);
        chk("wd_abort_pulse", 32'(bus.O_Abort), 0);
        chk("wd_rel_st",      32'(bus.O_St), 0);
        wait_grant(id, waited);
        chk("wd_next_id", id, 3);
        bus.I_Req = '0;

        // term arrives exactly when the idle count hits the limit
        repeat (64) step();
        bus.I_FTk[3] = mk(1'b1, 1'b1, 1'b1, 16'h0033);
        @(negedge clock);
        chk("co_abort", 32'(bus.O_Abort), 0);
        chk("co_ftk",   32'(bus.O_FTk_IF), 32'({3'b111, 16'h0033}));
        step();
        bus.I_FTk[3] = '0;
        @(negedge clock);
        chk("co_rel_st",   32'(bus.O_St), 0);
        chk("co_rel_busy", 32'(bus.O_Busy), 1);

        // move ptr to 2, then reset in the middle of port 2's transfer
        repeat (2) step();
        bus.I_Req = 4'b0010;
        wait_grant(id, waited);
        chk("rs_pre_id", id, 1);
        bus.I_Req = '0;
        xfer(1, 1);
        step();
        bus.I_Req = 4'b0100;
        wait_grant(id, waited);
        chk("rs_victim_id", id, 2);
        bus.I_Req = '0;
        bus.I_FTk[2] = mk(1'b1, 1'b0, 1'b0, 16'h0007);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        bus.I_FTk[2] = '0;
        @(negedge clock);
        chk("rs_st",    32'(bus.O_St), 0);
        chk("rs_busy",  32'(bus.O_Busy), 0);
        chk("rs_gid",   32'(bus.O_Grant_ID), 0);
        chk("rs_ftk",   32'(bus.O_FTk_IF), 0);
        chk("rs_abort", 32'(bus.O_Abort), 0);
        bus.I_Req = 4'hF;
        wait_grant(id, waited);
        chk("rs_contention_id", id, 0);
        bus.I_Req = '0;
        xfer(0, 0);
        repeat (3) step();

        chk("log_len", m_log.size(), 12);
        for (int i = 0; i < 12 && i < m_log.size(); i++) chk("model_log", m_log[i], log_exp[i]);
        chk("model_aborts", m_aborts, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        n_chk++;
        $display("FAIL global_timeout: got running expected finished at t=%0t", $time);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
